// File: rtl/pic_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pic_scheduler
// Purpose  : Picks which of NUM_PICS 256x128 ROM images is shown in each of
//            the three 128-row bands of a 256x384 window. It generates the
//            image ROM address and the valid flag for the ROM data. The
//            image-to-band mapping rotates every HOLD_FRAMES frames, or at
//            the next frame start after a manual step request.
// Ports    : clk        pixel clock, rising edge
//            rst_n      synchronous active-low reset
//            pause      (PIC_SCHED_PAUSE_EN only) freezes hold-based rotation
//            r, c       current VGA row / column
//            band_done  pulse on the last pixel position of a band
//            step_req   pulse requesting one manual rotation step
//            rom_addr   {r[6:0], c[7:0]}, latency 1
//            rom_sel    image index for the current band, latency 1
//            pix_valid  window flag aligned with synchronous-ROM data, latency 2
//            rot        current rotation offset (image shown in band 0)
// Config   : define PIC_SCHED_PAUSE_EN to add the pause input
// Revision : 1.0  initial release
// ============================================================================
module pic_scheduler #(
    parameter int NUM_PICS    = 4,
    parameter int HOLD_FRAMES = 60
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef PIC_SCHED_PAUSE_EN
    input  logic        pause,
`endif
    input  logic [9:0]  r,
    input  logic [9:0]  c,
    input  logic        band_done,
    input  logic        step_req,
    output logic [14:0] rom_addr,
    output logic [1:0]  rom_sel,
    output logic        pix_valid,
    output logic [1:0]  rot
);

    localparam logic [2:0] C_NUM       = 3'(NUM_PICS);
    localparam logic [1:0] C_ROT_LAST  = 2'(NUM_PICS - 1);
    localparam logic [9:0] C_HOLD_LAST = 10'(HOLD_FRAMES - 1);

    typedef enum logic [2:0] {
        WAIT_FRAME = 3'd0,
        BAND0      = 3'd1,
        BAND1      = 3'd2,
        BAND2      = 3'd3,
        BLANK      = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_rot;
    logic [1:0]  w_rot_nxt;
    logic [9:0]  r_frame_cnt;
    logic        r_pending;
    logic [14:0] r_rom_addr;
    logic [1:0]  r_rom_sel;
    logic [1:0]  w_sel_nxt;
    logic        r_win_d1;
    logic        r_pix_valid;

    logic w_pause;
    logic w_fs;
    logic w_run_fs;
    logic w_expire;
    logic w_advance;
    logic w_in_win;

`ifdef PIC_SCHED_PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    // (base + k) mod NUM_PICS; base < NUM_PICS and k <= 2 < NUM_PICS, so a
    // single conditional subtract is enough.
    function automatic logic [1:0] f_mod_add(input logic [1:0] base, input logic [1:0] k);
        logic [2:0] s;
        s = {1'b0, base} + {1'b0, k};
        if (s >= C_NUM) begin
            s = s - C_NUM;
        end
        return s[1:0];
    endfunction

    assign w_fs = (r == 10'd0) && (c == 10'd0);

    // The frame start that leaves WAIT_FRAME only synchronises; rotation
    // bookkeeping runs on frame starts seen while already tracking frames.
    assign w_run_fs  = w_fs && (r_state != WAIT_FRAME);
    assign w_expire  = (r_frame_cnt == C_HOLD_LAST) && !w_pause;
    // Hold expiry and a pending step collapse into a single advance.
    assign w_advance = w_run_fs && (w_expire || r_pending || step_req);
    assign w_rot_nxt = !w_advance ? r_rot :
                       (r_rot == C_ROT_LAST) ? 2'd0 : r_rot + 2'd1;

    // Window valid only once synchronised, so outputs stay quiet after reset
    // until the first frame start.
    assign w_in_win = (r <= 10'd383) && (c <= 10'd255) &&
                      (w_fs || (r_state != WAIT_FRAME));

    always_comb begin
        w_state_nxt = r_state;
        if (w_fs) begin
            w_state_nxt = BAND0;
        end else begin
            case (r_state)
                BAND0:   if (band_done) w_state_nxt = BAND1;
                BAND1:   if (band_done) w_state_nxt = BAND2;
                BAND2:   if (band_done) w_state_nxt = BLANK;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Image for the pixel being presented now. The band_done pixel still
    // belongs to the band that is ending, so the current state decides.
    always_comb begin
        w_sel_nxt = r_rom_sel;
        if (w_fs) begin
            w_sel_nxt = f_mod_add(w_rot_nxt, 2'd0);
        end else begin
            case (r_state)
                BAND0:   w_sel_nxt = f_mod_add(r_rot, 2'd0);
                BAND1:   w_sel_nxt = f_mod_add(r_rot, 2'd1);
                BAND2:   w_sel_nxt = f_mod_add(r_rot, 2'd2);
                default: w_sel_nxt = r_rom_sel;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= WAIT_FRAME;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rot       <= 2'd0;
            r_frame_cnt <= 10'd0;
            r_pending   <= 1'b0;
        end else begin
            r_rot <= w_rot_nxt;
            if (w_run_fs) begin
                r_pending <= 1'b0;
                if (w_advance) begin
                    r_frame_cnt <= 10'd0;
                end else if (!w_pause) begin
                    r_frame_cnt <= r_frame_cnt + 10'd1;
                end
            end else if (step_req && (r_state != WAIT_FRAME)) begin
                // A second request while pending is simply absorbed.
                r_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rom_addr  <= 15'd0;
            r_rom_sel   <= 2'd0;
            r_win_d1    <= 1'b0;
            r_pix_valid <= 1'b0;
        end else begin
            r_rom_addr  <= {r[6:0], c[7:0]};
            r_rom_sel   <= w_sel_nxt;
            r_win_d1    <= w_in_win;
            r_pix_valid <= r_win_d1;
        end
    end

    assign rom_addr  = r_rom_addr;
    assign rom_sel   = r_rom_sel;
    assign pix_valid = r_pix_valid;
    assign rot       = r_rot;

endmodule
`default_nettype wire
